// File: rtl/md_unit.sv
// Multiply/divide unit with private HI/LO registers for the E stage.
// The result is computed at launch and committed after a fixed latency so the stall logic sees a fixed busy window.
module md_unit #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    logic [CW-1:0] cnt_r;
    logic          busy_r;
    logic [31:0]   hi_r;
    logic [31:0]   lo_r;
    logic [31:0]   pend_hi_r;
    logic [31:0]   pend_lo_r;
    logic          pend_commit_r;

    logic [31:0]   res_hi_s;
    logic [31:0]   res_lo_s;
    logic          res_commit_s;
    logic [63:0]   prod_s;
    logic [63:0]   uprod_s;
    logic signed [31:0] squot_s;
    logic signed [31:0] srem_s;

    assign prod_s  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign uprod_s = {32'd0, a} * {32'd0, b};

    // Signed divide with the divide-by-zero and INT_MIN/-1 overflow cases kept out of the divider.
    always_comb begin
        squot_s = 32'sd0;
        srem_s  = 32'sd0;
        if (b == 32'd0) begin
            squot_s = 32'sd0;
            srem_s  = 32'sd0;
        end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
            squot_s = 32'sh8000_0000;
            srem_s  = 32'sd0;
        end else begin
            squot_s = $signed(a) / $signed(b);
            srem_s  = $signed(a) % $signed(b);
        end
    end

    // Result selection by opcode; a zero divisor suppresses the commit.
    always_comb begin
        res_hi_s     = 32'd0;
        res_lo_s     = 32'd0;
        res_commit_s = 1'b1;
        case (op)
            2'b00: begin
                res_hi_s = prod_s[63:32];
                res_lo_s = prod_s[31:0];
            end
            2'b01: begin
                res_hi_s = uprod_s[63:32];
                res_lo_s = uprod_s[31:0];
            end
            2'b10: begin
                res_hi_s     = srem_s;
                res_lo_s     = squot_s;
                res_commit_s = (b != 32'd0);
            end
            2'b11: begin
                if (b != 32'd0) begin
                    res_hi_s = a % b;
                    res_lo_s = a / b;
                end else begin
                    res_hi_s = 32'd0;
                    res_lo_s = 32'd0;
                end
                res_commit_s = (b != 32'd0);
            end
            default: begin
                res_hi_s     = 32'd0;
                res_lo_s     = 32'd0;
                res_commit_s = 1'b0;
            end
        endcase
    end

    // Launch/countdown/commit state; busy is kept registered alongside the counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r         <= {CW{1'b0}};
            busy_r        <= 1'b0;
            hi_r          <= 32'd0;
            lo_r          <= 32'd0;
            pend_hi_r     <= 32'd0;
            pend_lo_r     <= 32'd0;
            pend_commit_r <= 1'b0;
        end else if (cnt_r == {CW{1'b0}}) begin
            if (start) begin
                pend_hi_r     <= res_hi_s;
                pend_lo_r     <= res_lo_s;
                pend_commit_r <= res_commit_s;
                cnt_r         <= op[1] ? CW'(DIV_LAT) : CW'(MULT_LAT);
                busy_r        <= 1'b1;
            end else begin
                if (mthi) begin
                    hi_r <= a;
                end
                if (mtlo) begin
                    lo_r <= a;
                end
            end
        end else begin
            cnt_r <= cnt_r - CW'(1);
            if (cnt_r == CW'(1)) begin
                busy_r <= 1'b0;
                if (pend_commit_r) begin
                    hi_r <= pend_hi_r;
                    lo_r <= pend_lo_r;
                end
            end
        end
    end

    assign busy = busy_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed vector table, hand-written corner sequences,
// and randomized operations checked against a 64-bit arithmetic reference model.
module tb_md_unit;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic        mthi;
    logic        mtlo;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_unit #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .mthi(mthi), .mtlo(mtlo),
        .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on sign/zero-extended operands.
    function automatic void model_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint          sx = $signed(x);
        longint          sy = $signed(y);
        longint unsigned ux = x;
        longint unsigned uy = y;
        longint          sq;
        longint          sr;
        longint unsigned up;
        case (o)
            2'b00: begin up = sx * sy; m_hi = up[63:32]; m_lo = up[31:0]; end
            2'b01: begin up = ux * uy; m_hi = up[63:32]; m_lo = up[31:0]; end
            2'b10: if (y != 32'd0) begin
                sq = sx / sy; sr = sx % sy; m_lo = sq[31:0]; m_hi = sr[31:0];
            end
            default: if (y != 32'd0) begin
                up = ux / uy; m_lo = up[31:0]; up = ux % uy; m_hi = up[31:0];
            end
        endcase
    endfunction

    task automatic idle_inputs();
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
    endtask

    task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
        mthi = 1'b1; a = h; @(negedge clk);
        mthi = 1'b0; mtlo = 1'b1; a = l; @(negedge clk);
        mtlo = 1'b0; a = 32'd0;
        m_hi = h; m_lo = l;
    endtask

    // Launch one operation, count busy cycles (bounded) and check latency and result.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
        int n;
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = 32'd0; b = 32'd0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk({name, " busy_cycles"}, n, o[1] ? DIV_LAT : MULT_LAT);
        chk({name, " hi"}, hi, eh);
        chk({name, " lo"}, lo, el);
    endtask

    vec_t vecs[6];

    initial begin
        int n;
        vecs[0] = '{32'h0, 32'h0, 2'b00, 32'd3, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFF4};
        vecs[1] = '{32'h0, 32'h0, 2'b01, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE};
        vecs[2] = '{32'h0, 32'h0, 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{32'h1, 32'h1, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000};
        vecs[4] = '{32'h11, 32'h22, 2'b11, 32'd9, 32'd0, 32'h11, 32'h22};
        vecs[5] = '{32'h0, 32'h0, 2'b11, 32'd100, 32'd7, 32'd2, 32'd14};

        idle_inputs();
        reset = 1'b1;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);

        for (int i = 0; i < 6; i++) begin
            write_hilo(vecs[i].pre_hi, vecs[i].pre_lo);
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].exp_hi, vecs[i].exp_lo);
        end

        // start and mthi during a busy div are ignored.
        write_hilo(32'h0, 32'h0);
        start = 1'b1; op = 2'b11; a = 32'd50; b = 32'd8;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        @(negedge clk); n++;
        start = 1'b1; op = 2'b00; mthi = 1'b1; a = 32'hDEAD; b = 32'd3;
        @(negedge clk); n++;
        start = 1'b0; mthi = 1'b0; a = 32'd0; b = 32'd0;
        while (busy === 1'b1 && n < 40) begin
            @(negedge clk); n++;
        end
        chk("busy_ignore cycles", n - 1, DIV_LAT);
        chk("busy_ignore hi", hi, 32'd2);
        chk("busy_ignore lo", lo, 32'd6);

        mthi = 1'b1; mtlo = 1'b1; a = 32'h5;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0; a = 32'd0;
        chk("mthi_mtlo hi", hi, 32'h5);
        chk("mthi_mtlo lo", lo, 32'h5);

        // start beats mthi/mtlo when idle.
        start = 1'b1; mthi = 1'b1; mtlo = 1'b1; op = 2'b01; a = 32'd6; b = 32'd7;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0; a = 32'd0; b = 32'd0;
        chk("start_wins busy", {31'd0, busy}, 32'd1);
        chk("start_wins hi", hi, 32'h5);
        repeat (MULT_LAT) @(negedge clk);
        chk("start_wins res_hi", hi, 32'd0);
        chk("start_wins res_lo", lo, 32'd42);

        // Reset in cycle 3 of a mult discards the pending result.
        start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset busy", {31'd0, busy}, 32'd0);
        chk("midreset hi", hi, 32'd0);
        chk("midreset lo", lo, 32'd0);
        for (int k = 0; k < MULT_LAT; k++) begin
            @(negedge clk);
            chk($sformatf("midreset late%0d", k), {busy, hi[30:0]} | lo, 32'd0);
        end

        // Randomized operations against the reference model.
        m_hi = 32'd0; m_lo = 32'd0;
        for (int r = 0; r < 40; r++) begin
            logic [1:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 4))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 20));
                2: rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) ra = 32'h8000_0000;
            if ($urandom_range(0, 2) == 0) write_hilo($urandom, $urandom);
            model_op(ro, ra, rb);
            run_op($sformatf("rand%0d op%0d", r, ro), ro, ra, rb, m_hi, m_lo);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
